multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum cycles a memory state SHALL wait for mem_ready before aborting (range 1..255).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-high; forces IDLE/FETCH entry.
REQ-005 opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-006 jump_reg  in  1  jr indication from the ALU control decoder (funct==8 while alu_op==2).
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-009 alu_op  out  2  0 = add, 1 = subtract, 2 = use funct field, 3 = and; drives the ALU control decoder.
REQ-010 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-011 alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left by 2.
REQ-012 pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = register A.
REQ-013 Single-bit outputs pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, mem_fault, illegal_op.
REQ-014 state  out  4  current state encoding, for debug.

Function
REQ-015 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JUMP 11, JR 12.
REQ-016 Outputs SHALL be decoded combinationally from state, plus the single inputs named in this section; any unlisted output is 0.
REQ-017 FETCH behaviour:
- asserts mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
- asserts ir_write=1 and pc_en=1 only in the cycle mem_ready=1, then moves to DECODE.
- otherwise holds in FETCH.
REQ-018 DECODE behaviour:
- asserts alu_src_a=0, alu_src_b=3, alu_op=0.
- branches on opcode: 0 -> RTYPEEX; 35 or 43 -> MEMADR; 4 -> BEQEX; 8 or 12 -> IMMEX; 2 -> JUMP.
- any other opcode -> FETCH, with illegal_op=1 for that one DECODE cycle.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0; goes to MEMRD if opcode==35, to MEMWR if opcode==43.
REQ-020 MEMRD: mem_read=1, iord=1; goes to MEMWB on mem_ready.
REQ-021 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; goes to FETCH.
REQ-022 MEMWR: mem_write=1, iord=1; goes to FETCH on mem_ready.
REQ-023 RTYPEEX behaviour:
- asserts alu_src_a=1, alu_src_b=0, alu_op=2.
- next state is JR if jump_reg=1, otherwise RTYPEWB.
REQ-024 RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_op=2; goes to FETCH.
REQ-025 JR: pc_source=3, pc_en=1; goes to FETCH; register write SHALL NOT occur on the jr path.
REQ-026 BEQEX: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1, pc_en=zero; goes to FETCH.
REQ-027 IMMEX: alu_src_a=1, alu_src_b=2, alu_op=0 if opcode==8, alu_op=3 if opcode==12; goes to IMMWB.
REQ-028 IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0, alu_op held as in IMMEX; goes to FETCH.
REQ-029 JUMP: pc_source=2, pc_en=1; goes to FETCH.
REQ-030 Wait counter (8 bits):
- clears on every state entry and increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
- when it reaches WAIT_LIMIT with mem_ready still 0, mem_fault SHALL pulse 1 for exactly that cycle and the next state SHALL be FETCH.
- no ir_write, pc_en, or register write occurs on abort.
REQ-031 If mem_ready and the timeout coincide, mem_ready SHALL win: normal completion, no mem_fault.
REQ-032 Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, jr 4, addi/andi 4, beq 3, j 3.

Reset
REQ-033 While reset=1 the block SHALL hold state=FETCH and wait counter=0, independent of clk.
REQ-034 Outputs during reset SHALL be the FETCH decode with mem_ready treated as 0; mem_fault=0 and illegal_op=0.
REQ-035 Reset asserted mid-instruction SHALL abandon the instruction with no further reg_write, mem_write or pc_en.

Verification
REQ-036 lw, opcode=35, mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-037 R-type with jump_reg=1 -> states 0,1,6,12,0; alu_op=2 in state 6; pc_source=3 and pc_en=1 in state 12; reg_write never 1.
REQ-038 beq, opcode=4: with zero=1 -> pc_en=1 in state 8; with zero=0 -> pc_en=0; both return to FETCH next.
REQ-039 andi, opcode=12 -> alu_op=3 in IMMEX and IMMWB; addi, opcode=8 -> alu_op=0.
REQ-040 WAIT_LIMIT=3, mem_ready=0 in FETCH -> mem_fault=1 on the 4th FETCH cycle, ir_write never asserted; mem_ready=1 on that same cycle -> DECODE, mem_fault=0.
REQ-041 opcode=63 -> illegal_op=1 for one cycle in DECODE, then FETCH; reset asserted in MEMWR -> state=0 immediately and mem_write=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM. Outputs decode combinationally from the
// current state plus opcode, jump_reg, zero and mem_ready. Memory states use
// a bounded wait counter and abort to FETCH with a one-cycle mem_fault pulse.
module multicycle_control_unit #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       jump_reg,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       mem_fault,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StImmEx   = 4'd9,
    StImmWb   = 4'd10,
    StJump    = 4'd11,
    StJr      = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpAddi  = 6'd8;
  localparam logic [5:0] OpAndi  = 6'd12;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;

  localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ready;
  logic       timeout;

  // mem_ready is ignored while reset is held so the FETCH decode stays inert.
  assign ready   = mem_ready & ~reset;
  assign timeout = (cnt_q == WaitLimit) & ~ready & ~reset;
  assign state   = state_q;

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    alu_op     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_source  = 2'd0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_fault  = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          mem_fault = 1'b1;
        end
      end
      StDecode: begin
        alu_src_b = 2'd3;
        case (opcode)
          OpRtype:      state_d = StRtypeEx;
          OpLw, OpSw:   state_d = StMemAdr;
          OpBeq:        state_d = StBeqEx;
          OpAddi, OpAndi: state_d = StImmEx;
          OpJ:          state_d = StJump;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (opcode == OpLw) state_d = StMemRd;
        else if (opcode == OpSw) state_d = StMemWr;
        else state_d = StFetch;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          mem_fault = 1'b1;
          state_d   = StFetch;
        end
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          mem_fault = 1'b1;
          state_d   = StFetch;
        end
      end
      StRtypeEx: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = jump_reg ? StJr : StRtypeWb;
      end
      StRtypeWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = 2'd2;
        state_d   = StFetch;
      end
      StBeqEx: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_source = 2'd1;
        pc_en     = zero;
        state_d   = StFetch;
      end
      StImmEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = (opcode == OpAndi) ? 2'd3 : 2'd0;
        state_d   = StImmWb;
      end
      StImmWb: begin
        reg_write = 1'b1;
        alu_op    = (opcode == OpAndi) ? 2'd3 : 2'd0;
        state_d   = StFetch;
      end
      StJump: begin
        pc_source = 2'd2;
        pc_en     = 1'b1;
        state_d   = StFetch;
      end
      StJr: begin
        pc_source = 2'd3;
        pc_en     = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Wait counter: cleared on every state entry (including the FETCH re-entry
  // after an abort), counts stalled cycles in the memory-waiting states.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || mem_fault) begin
      cnt_d = 8'd0;
    end else if (state_q == StFetch || state_q == StMemRd || state_q == StMemWr) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each stimulus cycle pushes the hand-computed output vector
// into a queue; a monitor on the falling edge pops and compares.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       jump_reg, zero, mem_ready;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic       alu_src_a, pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, mem_fault, illegal_op;
  logic [3:0] state;

  multicycle_control_unit #(.WAIT_LIMIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .jump_reg   (jump_reg),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .mem_fault  (mem_fault),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [20:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   compared   = 0;
  int   mismatched = 0;

  // Flag order: pc_en iord mem_read mem_write ir_write reg_write reg_dst
  //             mem_to_reg mem_fault illegal_op
  localparam logic [9:0] FNone       = 10'b0000000000;
  localparam logic [9:0] FFetchRdy   = 10'b1010100000;
  localparam logic [9:0] FFetchWait  = 10'b0010000000;
  localparam logic [9:0] FFetchFault = 10'b0010000010;
  localparam logic [9:0] FIll        = 10'b0000000001;
  localparam logic [9:0] FMemRd      = 10'b0110000000;
  localparam logic [9:0] FMemRdFault = 10'b0110000010;
  localparam logic [9:0] FMemWb      = 10'b0000010100;
  localparam logic [9:0] FMemWr      = 10'b0101000000;
  localparam logic [9:0] FRtWb       = 10'b0000011000;
  localparam logic [9:0] FPc         = 10'b1000000000;
  localparam logic [9:0] FImmWb      = 10'b0000010000;

  function automatic logic [20:0] mk(input logic [3:0] st, input logic [1:0] aop,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic [9:0] f);
    return {st, aop, sa, sb, ps, f};
  endfunction

  logic [20:0] act;
  assign act = {state, alu_op, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
                mem_write, ir_write, reg_write, reg_dst, mem_to_reg, mem_fault, illegal_op};

  // Monitor: outputs are valid every cycle; compare whenever an expectation is queued.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      compared++;
      if (act !== e.v) begin
        mismatched++;
        $display("FAIL %s: got state=%0d bits=%b, expected state=%0d bits=%b",
                 e.name, act[20:17], act[16:0], e.v[20:17], e.v[16:0]);
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic [5:0] op,
                      input logic jr, input logic z, input logic mr, input logic [20:0] v);
    exp_t x;
    reset     = rst;
    opcode    = op;
    jump_reg  = jr;
    zero      = z;
    mem_ready = mr;
    x.name = name;
    x.v    = v;
    q.push_back(x);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Common vectors.
  logic [20:0] vfr, vfw, vff, vdec, vma;
  initial begin
    vfr  = mk(4'd0, 2'd0, 1'b0, 2'd1, 2'd0, FFetchRdy);
    vfw  = mk(4'd0, 2'd0, 1'b0, 2'd1, 2'd0, FFetchWait);
    vff  = mk(4'd0, 2'd0, 1'b0, 2'd1, 2'd0, FFetchFault);
    vdec = mk(4'd1, 2'd0, 1'b0, 2'd3, 2'd0, FNone);
    vma  = mk(4'd2, 2'd0, 1'b1, 2'd2, 2'd0, FNone);
  end

  initial begin
    #0;
    // Reset: mem_ready=1 must be ignored, FETCH decode with no ir_write/pc_en.
    step("reset_hold", 1'b1, 6'd35, 1'b0, 1'b0, 1'b1, vfw);
    step("reset_hold2", 1'b1, 6'd35, 1'b0, 1'b0, 1'b1, vfw);

    // lw, zero-wait: 0,1,2,3,4
    step("lw_fetch", 1'b0, 6'd35, 1'b0, 1'b0, 1'b1, vfr);
    step("lw_decode", 1'b0, 6'd35, 1'b0, 1'b0, 1'b1, vdec);
    step("lw_memadr", 1'b0, 6'd35, 1'b0, 1'b0, 1'b1, vma);
    step("lw_memrd", 1'b0, 6'd35, 1'b0, 1'b0, 1'b1, mk(4'd3, 2'd0, 1'b0, 2'd0, 2'd0, FMemRd));
    step("lw_memwb", 1'b0, 6'd35, 1'b0, 1'b0, 1'b1, mk(4'd4, 2'd0, 1'b0, 2'd0, 2'd0, FMemWb));

    // sw: 0,1,2,5
    step("sw_fetch", 1'b0, 6'd43, 1'b0, 1'b0, 1'b1, vfr);
    step("sw_decode", 1'b0, 6'd43, 1'b0, 1'b0, 1'b1, vdec);
    step("sw_memadr", 1'b0, 6'd43, 1'b0, 1'b0, 1'b1, vma);
    step("sw_memwr", 1'b0, 6'd43, 1'b0, 1'b0, 1'b1, mk(4'd5, 2'd0, 1'b0, 2'd0, 2'd0, FMemWr));

    // jr: 0,1,6,12 with no reg_write
    step("jr_fetch", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, vfr);
    step("jr_decode", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, vdec);
    step("jr_rtypeex", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, mk(4'd6, 2'd2, 1'b1, 2'd0, 2'd0, FNone));
    step("jr_jr", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, mk(4'd12, 2'd0, 1'b0, 2'd0, 2'd3, FPc));

    // R-type: 0,1,6,7
    step("rt_fetch", 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, vfr);
    step("rt_decode", 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, vdec);
    step("rt_rtypeex", 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, mk(4'd6, 2'd2, 1'b1, 2'd0, 2'd0, FNone));
    step("rt_rtypewb", 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, mk(4'd7, 2'd2, 1'b0, 2'd0, 2'd0, FRtWb));

    // beq taken and not taken
    step("beq1_fetch", 1'b0, 6'd4, 1'b0, 1'b1, 1'b1, vfr);
    step("beq1_decode", 1'b0, 6'd4, 1'b0, 1'b1, 1'b1, vdec);
    step("beq1_beqex", 1'b0, 6'd4, 1'b0, 1'b1, 1'b1, mk(4'd8, 2'd1, 1'b1, 2'd0, 2'd1, FPc));
    step("beq0_fetch", 1'b0, 6'd4, 1'b0, 1'b0, 1'b1, vfr);
    step("beq0_decode", 1'b0, 6'd4, 1'b0, 1'b0, 1'b1, vdec);
    step("beq0_beqex", 1'b0, 6'd4, 1'b0, 1'b0, 1'b1, mk(4'd8, 2'd1, 1'b1, 2'd0, 2'd1, FNone));

    // andi then addi
    step("andi_fetch", 1'b0, 6'd12, 1'b0, 1'b0, 1'b1, vfr);
    step("andi_decode", 1'b0, 6'd12, 1'b0, 1'b0, 1'b1, vdec);
    step("andi_immex", 1'b0, 6'd12, 1'b0, 1'b0, 1'b1, mk(4'd9, 2'd3, 1'b1, 2'd2, 2'd0, FNone));
    step("andi_immwb", 1'b0, 6'd12, 1'b0, 1'b0, 1'b1, mk(4'd10, 2'd3, 1'b0, 2'd0, 2'd0, FImmWb));
    step("addi_fetch", 1'b0, 6'd8, 1'b0, 1'b0, 1'b1, vfr);
    step("addi_decode", 1'b0, 6'd8, 1'b0, 1'b0, 1'b1, vdec);
    step("addi_immex", 1'b0, 6'd8, 1'b0, 1'b0, 1'b1, mk(4'd9, 2'd0, 1'b1, 2'd2, 2'd0, FNone));
    step("addi_immwb", 1'b0, 6'd8, 1'b0, 1'b0, 1'b1, mk(4'd10, 2'd0, 1'b0, 2'd0, 2'd0, FImmWb));

    // j: 0,1,11
    step("j_fetch", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, vfr);
    step("j_decode", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, vdec);
    step("j_jump", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, mk(4'd11, 2'd0, 1'b0, 2'd0, 2'd2, FPc));

    // Illegal opcode: one-cycle illegal_op, then FETCH
    step("ill_fetch", 1'b0, 6'd63, 1'b0, 1'b0, 1'b1, vfr);
    step("ill_decode", 1'b0, 6'd63, 1'b0, 1'b0, 1'b1, mk(4'd1, 2'd0, 1'b0, 2'd3, 2'd0, FIll));

    // FETCH timeout at WAIT_LIMIT=3: fault on the 4th stalled cycle
    step("to_wait0", 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, vfw);
    step("to_wait1", 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, vfw);
    step("to_wait2", 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, vfw);
    step("to_fault", 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, vff);
    // Counter restarts; ready on the limit cycle wins over the timeout
    step("tr_wait0", 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, vfw);
    step("tr_wait1", 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, vfw);
    step("tr_wait2", 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, vfw);
    step("tr_ready", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, vfr);
    step("tr_decode", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, vdec);
    step("tr_jump", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, mk(4'd11, 2'd0, 1'b0, 2'd0, 2'd2, FPc));

    // MEMRD timeout: abort to FETCH without MEMWB
    step("lwto_fetch", 1'b0, 6'd35, 1'b0, 1'b0, 1'b1, vfr);
    step("lwto_decode", 1'b0, 6'd35, 1'b0, 1'b0, 1'b0, vdec);
    step("lwto_memadr", 1'b0, 6'd35, 1'b0, 1'b0, 1'b0, vma);
    for (int i = 0; i < 3; i++)
      step("lwto_memrd_wait", 1'b0, 6'd35, 1'b0, 1'b0, 1'b0,
           mk(4'd3, 2'd0, 1'b0, 2'd0, 2'd0, FMemRd));
    step("lwto_memrd_fault", 1'b0, 6'd35, 1'b0, 1'b0, 1'b0,
         mk(4'd3, 2'd0, 1'b0, 2'd0, 2'd0, FMemRdFault));
    step("lwto_back_fetch", 1'b0, 6'd43, 1'b0, 1'b0, 1'b1, vfr);

    // Reset asserted while in MEMWR: immediate FETCH, no mem_write
    step("rst_decode", 1'b0, 6'd43, 1'b0, 1'b0, 1'b0, vdec);
    step("rst_memadr", 1'b0, 6'd43, 1'b0, 1'b0, 1'b0, vma);
    step("rst_memwr", 1'b0, 6'd43, 1'b0, 1'b0, 1'b0, mk(4'd5, 2'd0, 1'b0, 2'd0, 2'd0, FMemWr));
    step("rst_memwr_abort", 1'b1, 6'd43, 1'b0, 1'b0, 1'b1, vfw);
    step("rst_release", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, vfr);
    step("rst_after_decode", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, vdec);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
